// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory load/store path: access sizes, LSU states, memory size.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MEM_BYTES_DEFAULT = 16384;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core-side request/response handshake plus byte-addressed data memory port.
interface lsu_mem_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  mem_en;
    logic                  rd_wr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, rd_wr, read_addr, write_addr, write_data
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, rd_wr, read_addr, write_addr, write_data
    );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the low byte/half/word lane of a memory word and sign- or zero-extends it.
module lsu_load_align
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{(DATA_WIDTH-8){~unsigned_i & word_i[7]}}, word_i[7:0]};
            SZ_HALF: data_o = {{(DATA_WIDTH-16){~unsigned_i & word_i[15]}}, word_i[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding RV32I load/store initiator; sub-word stores are read-modify-write
// because the memory always writes a full 4-byte word at write_addr.
module lsu_mem_master
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_master_if.master bus
);

    // Highest legal start address; every access touches 4 bytes.
    localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MEM_BYTES - 4);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic                  err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    logic                  req_fault;

    assign req_fault = (bus.req_size == 2'b11) || (bus.req_addr > MaxAddr);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = req_fault;
                    if (req_fault) begin
                        state_d = StResp;
                    end else if (!bus.req_we || bus.req_size != SZ_WORD) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                word_d  = bus.read_data;
                state_d = we_q ? StWrite : StResp;
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
        end
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .word_i    (word_q),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .data_o    (load_data)
    );

    always_comb begin
        merge_data = wdata_q;
        case (size_q)
            SZ_BYTE: merge_data = {word_q[DATA_WIDTH-1:8], wdata_q[7:0]};
            SZ_HALF: merge_data = {word_q[DATA_WIDTH-1:16], wdata_q[15:0]};
            default: merge_data = wdata_q;
        endcase
    end

    // rd_wr must stay high outside WRITE: the memory writes on rd_wr=0 regardless of mem_en.
    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = (state_q == StResp && !we_q && !err_q) ? load_data : '0;
    assign bus.resp_err   = (state_q == StResp) && err_q;
    assign bus.mem_en     = (state_q == StRead) || (state_q == StWrite);
    assign bus.rd_wr      = (state_q != StWrite);
    assign bus.read_addr  = (state_q == StRead) ? addr_q : '0;
    assign bus.write_addr = (state_q == StWrite) ? addr_q : '0;
    assign bus.write_data = (state_q == StWrite) ? merge_data : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a byte-addressed memory model.
module tb_lsu_mem_master;
    import riscv_mem_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned MB = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   wr_count = 0;
    logic [7:0] mem [MB];

    lsu_mem_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    lsu_mem_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_BYTES (MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Memory writes 4 bytes whenever rd_wr is low, independent of mem_en.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MB); i++) mem[i] <= '0;
        end else if (bus.rd_wr === 1'b0) begin
            wr_count = wr_count + 1;
            if (bus.write_addr <= 32'(MB - 4)) begin
                for (int b = 0; b < 4; b++) mem[int'(bus.write_addr) + b] <= bus.write_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        bus.read_data = '0;
        if (bus.read_addr <= 32'(MB - 4)) begin
            for (int b = 0; b < 4; b++) bus.read_data[8*b +: 8] = mem[int'(bus.read_addr) + b];
        end
    end

    function automatic logic [31:0] peek(input int addr);
        return {mem[addr + 3], mem[addr + 2], mem[addr + 1], mem[addr]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic finish_resp(input int lat0, output int lat, output logic [31:0] rdata,
                               output logic err);
        lat = lat0;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        finish_resp(1, lat, rdata, err);
    endtask

    int          lat;
    int          w0;
    logic [31:0] rd;
    logic        er;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", 32'(bus.resp_err), 0);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_rd_wr", 32'(bus.rd_wr), 1);
        check("rst_read_addr", bus.read_addr, 0);
        check("rst_write_addr", bus.write_addr, 0);
        check("rst_write_data", bus.write_data, 0);
        mem_init = 1'b0;
        rst      = 1'b0;

        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        check("sw_lat", 32'(lat), 2);
        check("sw_err", 32'(er), 0);
        check("sw_rdata", rd, 0);
        check("sw_mem", peek(32'h10), 32'hDEADBEEF);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_lat", 32'(lat), 2);
        check("lw_err", 32'(er), 0);

        // SB at 0x11 merges into the word 0x11..0x14 = 0x00DEADBE.
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFFFF55, lat, rd, er);
        check("sb_lat", 32'(lat), 3);
        check("sb_err", 32'(er), 0);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, lat, rd, er);
        check("lbu_11", rd, 32'h00000055);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, lat, rd, er);
        check("lb_12", rd, 32'hFFFFFFAD);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("lw_10_after_sb", rd, 32'hDEAD55EF);
        check("sb_byte_14", peek(32'h14), 32'h0);

        do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h000080F0, lat, rd, er);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("lb_20", rd, 32'hFFFFFFF0);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, lat, rd, er);
        check("lbu_20", rd, 32'h000000F0);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("lh_20", rd, 32'hFFFF80F0);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, lat, rd, er);
        check("lhu_20", rd, 32'h000080F0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0, lat, rd, er);
        check("lw_unaligned_21", rd, 32'h00000080);
        check("lw_unaligned_err", 32'(er), 0);

        do_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h11223344, lat, rd, er);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h30, 32'h1234ABCD, lat, rd, er);
        check("sh_lat", 32'(lat), 3);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, lat, rd, er);
        check("lw_30_after_sh", rd, 32'h1122ABCD);

        do_req(1'b0, SZ_WORD, 1'b0, 32'h3FFC, 32'h0, lat, rd, er);
        check("lw_top_err", 32'(er), 0);
        check("lw_top_rdata", rd, 32'h0);

        w0 = wr_count;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h3FFD, 32'h0, lat, rd, er);
        check("flt_lw_err", 32'(er), 1);
        check("flt_lw_rdata", rd, 0);
        check("flt_lw_lat", 32'(lat), 1);
        do_req(1'b1, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'h12345678, lat, rd, er);
        check("flt_sw_err", 32'(er), 1);
        check("flt_sw_rdata", rd, 0);
        check("flt_sw_lat", 32'(lat), 1);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rd, er);
        check("flt_size_err", 32'(er), 1);
        check("flt_size_rdata", rd, 0);
        check("flt_size_lat", 32'(lat), 1);
        check("flt_no_writes", 32'(wr_count - w0), 0);

        // Backpressure: a second request is held on req_valid while the first response waits.
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h20;
        @(posedge clk);
        #1;
        bus.req_size = SZ_BYTE;
        bus.req_addr = 32'h10;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.resp_valid), 1);
            check("bp_rdata", bus.resp_rdata, 32'h000080F0);
            check("bp_req_ready", 32'(bus.req_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("bp_idle_ready", 32'(bus.req_ready), 1);
        check("bp_idle_valid", 32'(bus.resp_valid), 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("bp_second_mem_en", 32'(bus.mem_en), 1);
        check("bp_second_addr", bus.read_addr, 32'h10);
        check("bp_second_ready", 32'(bus.req_ready), 0);
        finish_resp(1, lat, rd, er);
        check("bp_second_rdata", rd, 32'hFFFFFFEF);
        check("bp_second_lat", 32'(lat), 2);

        // Reset during the READ cycle of an SH must abort without touching memory.
        do_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFEF00D, lat, rd, er);
        w0 = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_HALF;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h00009999;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_abort_in_read", 32'(bus.mem_en), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_abort_rd_wr", 32'(bus.rd_wr), 1);
        check("rst_abort_idle", 32'(bus.req_ready), 1);
        check("rst_abort_valid", 32'(bus.resp_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_abort_no_resp", 32'(bus.resp_valid), 0);
        check("rst_abort_no_write", 32'(wr_count - w0), 0);
        check("rst_abort_mem", peek(32'h40), 32'hCAFEF00D);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, lat, rd, er);
        check("rst_abort_lw", rd, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
